ysyx_041514_if_fetch: RTL and testbench

//  IF stage directly downstream of the PC register. Takes the pre-IF fetch

---
 rtl/ysyx_041514_if_fetch.sv | 160 ++++++++++++++++
 tb/tb_ysyx_041514_if_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041514_if_fetch.sv
// ysyx_041514_if_fetch
//   IF stage that sits directly after the PC register. It issues one icache
//   request at a time, picks the addressed 32-bit half of the returned
//   8-byte word, and presents {inst, pc, valid, misalign} to IF/ID.
//   Pipeline stall/flush bit 1 (IF) is honoured. While a fetch is in
//   flight, the stage raises a stall request.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   stall_valid_i[5:0]    stall bus (bit 1 used)
//   flush_valid_i[5:0]    flush bus (bit 1 used)
//   read_req_i, pc_next_i fetch request and address from the PC register
//   icache_req_*          request handshake and 8-byte aligned address
//   icache_rdata_*        returned line word
//   inst_*_o              instruction, PC, valid pulse, misalign exception
//   if_stall_req_o        high while a fetch is outstanding (REQ/WAIT/DROP)
module ysyx_041514_if_fetch #(
  parameter int               XLEN   = 64,
  parameter int               ADDR_W = 32,
  parameter logic [XLEN-1:0]  PC_RST = 64'h8000_0000,
  parameter logic [31:0]      NOP    = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_valid_i,
  input  logic [5:0]        flush_valid_i,
  input  logic              read_req_i,
  input  logic [ADDR_W-1:0] pc_next_i,
  output logic              icache_req_valid_o,
  input  logic              icache_req_ready_i,
  output logic [ADDR_W-1:0] icache_addr_o,
  input  logic              icache_rdata_valid_i,
  input  logic [63:0]       icache_rdata_i,
  output logic [31:0]       inst_o,
  output logic [XLEN-1:0]   inst_pc_o,
  output logic              inst_valid_o,
  output logic              inst_misalign_o,
  output logic              if_stall_req_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [31:0]       hold_q;
  logic [31:0]       inst_q;
  logic [XLEN-1:0]   inst_pc_q;
  logic              inst_valid_q, misalign_q, req_valid_q, stall_req_q;

  logic        stall_if, flush_if;
  logic [31:0] rdata_sel;

  assign stall_if  = stall_valid_i[1];
  assign flush_if  = flush_valid_i[1];
  // Bit 2 of the PC selects the upper or lower instruction of the 8-byte word.
  assign rdata_sel = fetch_pc_q[2] ? icache_rdata_i[63:32] : icache_rdata_i[31:0];

  logic unused_bus_bits;
  assign unused_bus_bits = ^{stall_valid_i[5:2], stall_valid_i[0],
                             flush_valid_i[5:2], flush_valid_i[0]};

  assign icache_req_valid_o = req_valid_q;
  assign icache_addr_o      = {fetch_pc_q[ADDR_W-1:3], 3'b000};
  assign inst_o             = inst_q;
  assign inst_pc_o          = inst_pc_q;
  assign inst_valid_o       = inst_valid_q;
  assign inst_misalign_o    = misalign_q;
  assign if_stall_req_o     = stall_req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= '0;
      hold_q       <= NOP;
      inst_q       <= NOP;
      inst_pc_q    <= PC_RST;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      req_valid_q  <= 1'b0;
      stall_req_q  <= 1'b0;
    end else begin
      // The output is a single-cycle pulse. When it is not valid, inst is NOP.
      inst_valid_q <= 1'b0;
      inst_q       <= NOP;
      misalign_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (read_req_i && !stall_if && !flush_if) begin
            fetch_pc_q <= pc_next_i;
            if (pc_next_i[1:0] != 2'b00) begin
              // A misaligned PC never reaches the icache. It reports the exception directly.
              inst_valid_q <= 1'b1;
              misalign_q   <= 1'b1;
              inst_pc_q    <= XLEN'(pc_next_i);
            end else begin
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              stall_req_q <= 1'b1;
            end
          end
        end
        REQ: begin
          // Flush takes priority. The icache must not be treated as having accepted.
          if (flush_if) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            stall_req_q <= 1'b0;
          end else if (icache_req_ready_i) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (flush_if) begin
            // If data arrives in the flush cycle, it is discarded here.
            // Otherwise, the late response is absorbed in DROP.
            if (icache_rdata_valid_i) begin
              state_q     <= IDLE;
              stall_req_q <= 1'b0;
            end else begin
              state_q <= DROP;
            end
          end else if (icache_rdata_valid_i) begin
            stall_req_q <= 1'b0;
            if (stall_if) begin
              hold_q  <= rdata_sel;
              state_q <= HOLD;
            end else begin
              inst_q       <= rdata_sel;
              inst_pc_q    <= XLEN'(fetch_pc_q);
              inst_valid_q <= 1'b1;
              state_q      <= IDLE;
            end
          end
        end
        HOLD: begin
          if (flush_if) begin
            state_q <= IDLE;
          end else if (!stall_if) begin
            inst_q       <= hold_q;
            inst_pc_q    <= XLEN'(fetch_pc_q);
            inst_valid_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        DROP: begin
          if (icache_rdata_valid_i) begin
            state_q     <= IDLE;
            stall_req_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_valid_q <= 1'b0;
          stall_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_041514_if_fetch.sv
module tb_ysyx_041514_if_fetch;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [63:0] PC_RST = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_valid_i, flush_valid_i;
  logic        read_req_i;
  logic [31:0] pc_next_i;
  logic        icache_req_valid_o, icache_req_ready_i;
  logic [31:0] icache_addr_o;
  logic        icache_rdata_valid_i;
  logic [63:0] icache_rdata_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        inst_valid_o, inst_misalign_o, if_stall_req_o;

  ysyx_041514_if_fetch dut (
    .clk(clk), .rst(rst),
    .stall_valid_i(stall_valid_i), .flush_valid_i(flush_valid_i),
    .read_req_i(read_req_i), .pc_next_i(pc_next_i),
    .icache_req_valid_o(icache_req_valid_o), .icache_req_ready_i(icache_req_ready_i),
    .icache_addr_o(icache_addr_o),
    .icache_rdata_valid_i(icache_rdata_valid_i), .icache_rdata_i(icache_rdata_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
    .inst_misalign_o(inst_misalign_o), .if_stall_req_o(if_stall_req_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   stall_cnt = 0, vld_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor. It pops the scoreboard on every valid pulse.
  // Between pulses, it checks that inst is NOP and misalign is 0.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_stall_req_o) stall_cnt++;
      if (inst_valid_o) begin
        exp_t e;
        vld_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("inst", {32'h0, inst_o}, {32'h0, e.inst});
          chk("inst_pc", inst_pc_o, e.pc);
          chk("misalign", {63'h0, inst_misalign_o}, {63'h0, e.mis});
        end
      end else begin
        chk("idle_inst_nop", {31'h0, inst_misalign_o, inst_o}, {32'h0, NOP});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Aligned fetch with a scripted icache response.
  // The accept comes after rdy_dly stalled REQ cycles.
  // The data arrives dat_dly cycles after the accept.
  task automatic fetch(input logic [31:0] pc, input int rdy_dly, input int dat_dly,
                       input logic [63:0] rd, input logic [31:0] exp_inst);
    exp_q.push_back('{exp_inst, {32'h0, pc}, 1'b0});
    pc_next_i = pc; read_req_i = 1'b1;
    tick();
    read_req_i = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      chk("req_valid_hold", {63'h0, icache_req_valid_o}, 64'd1);
      chk("addr_hold", {32'h0, icache_addr_o}, {32'h0, pc & 32'hFFFF_FFF8});
      tick();
    end
    chk("req_valid", {63'h0, icache_req_valid_o}, 64'd1);
    icache_req_ready_i = 1'b1;
    tick();
    icache_req_ready_i = 1'b0;
    for (int i = 1; i < dat_dly; i++) tick();
    icache_rdata_valid_i = 1'b1; icache_rdata_i = rd;
    tick();
    icache_rdata_valid_i = 1'b0;
  endtask

  initial begin
    int v0;
    rst = 1'b1; stall_valid_i = '0; flush_valid_i = '0; read_req_i = 1'b0;
    pc_next_i = '0; icache_req_ready_i = 1'b0; icache_rdata_valid_i = 1'b0;
    icache_rdata_i = '0;
    tick(); tick();
    chk("rst_inst", {32'h0, inst_o}, {32'h0, NOP});
    chk("rst_pc", inst_pc_o, PC_RST);
    chk("rst_flags", {60'h0, inst_valid_o, inst_misalign_o, if_stall_req_o, icache_req_valid_o}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: immediate accept, data arrives 2 cycles later, upper half selected
    stall_cnt = 0;
    fetch(32'h8000_0004, 0, 2, 64'hAAAA_BBBB_CCCC_DDDD, 32'hAAAA_BBBB);
    tick();
    chk("t1_stall_cycles", 64'(stall_cnt), 64'd3);

    // 2: accept delayed 4 cycles, lower half selected
    fetch(32'h8000_0008, 4, 1, 64'h1111_2222_3333_4444, 32'h3333_4444);
    tick();

    // 3: stall held when data returns, 3 cycles
    exp_q.push_back('{32'h5555_6666, 64'h8000_000C, 1'b0});
    pc_next_i = 32'h8000_000C; read_req_i = 1'b1; tick(); read_req_i = 1'b0;
    icache_req_ready_i = 1'b1; tick(); icache_req_ready_i = 1'b0;
    v0 = vld_cnt;
    stall_valid_i = 6'b000010;
    icache_rdata_valid_i = 1'b1; icache_rdata_i = 64'h5555_6666_7777_8888;
    tick(); icache_rdata_valid_i = 1'b0;
    tick(); tick();
    stall_valid_i = '0;
    chk("t3_no_valid_in_stall", 64'(vld_cnt - v0), 64'd0);
    tick(); tick();
    chk("t3_one_pulse", 64'(vld_cnt - v0), 64'd1);

    // 4: flush in WAIT, the late data is dropped, and the next fetch is clean
    v0 = vld_cnt;
    pc_next_i = 32'h8000_0014; read_req_i = 1'b1; tick(); read_req_i = 1'b0;
    icache_req_ready_i = 1'b1; tick(); icache_req_ready_i = 1'b0;
    flush_valid_i = 6'b000010; tick(); flush_valid_i = '0;
    chk("t4_drop_stall", {63'h0, if_stall_req_o}, 64'd1);
    tick();
    icache_rdata_valid_i = 1'b1; icache_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    tick(); icache_rdata_valid_i = 1'b0;
    chk("t4_idle_stall", {63'h0, if_stall_req_o}, 64'd0);
    tick();
    chk("t4_no_output", 64'(vld_cnt - v0), 64'd0);
    fetch(32'h8000_0010, 0, 2, 64'h9999_AAAA_BBBB_CCCC, 32'hBBBB_CCCC);
    tick();

    // 4b: flush in REQ, the request drops, and no accept happens
    pc_next_i = 32'h8000_0018; read_req_i = 1'b1; tick(); read_req_i = 1'b0;
    flush_valid_i = 6'b000010; icache_req_ready_i = 1'b1; tick();
    flush_valid_i = '0; icache_req_ready_i = 1'b0;
    chk("t4b_req_dropped", {62'h0, icache_req_valid_o, if_stall_req_o}, 64'd0);
    tick();

    // 5: a misaligned PC makes no icache request
    exp_q.push_back('{NOP, 64'h8000_0002, 1'b1});
    pc_next_i = 32'h8000_0002; read_req_i = 1'b1; tick(); read_req_i = 1'b0;
    chk("t5_no_req", {62'h0, icache_req_valid_o, if_stall_req_o}, 64'd0);
    tick(); tick();

    // 6: reset in WAIT, and the data that follows is ignored
    v0 = vld_cnt;
    pc_next_i = 32'h8000_0020; read_req_i = 1'b1; tick(); read_req_i = 1'b0;
    icache_req_ready_i = 1'b1; tick(); icache_req_ready_i = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    icache_rdata_valid_i = 1'b1; icache_rdata_i = 64'h0123_4567_89AB_CDEF;
    tick(); icache_rdata_valid_i = 1'b0;
    tick();
    chk("t6_inst", {32'h0, inst_o}, {32'h0, NOP});
    chk("t6_pc", inst_pc_o, PC_RST);
    chk("t6_flags", {60'h0, inst_valid_o, inst_misalign_o, if_stall_req_o, icache_req_valid_o}, 64'd0);
    chk("t6_no_output", 64'(vld_cnt - v0), 64'd0);

    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
